// File: rtl/counter_arbiter_pkg.sv
// Shared types and defaults for the round-robin counter arbiter.
// State encoding is fixed so traces read the same across tools.
package counter_arbiter_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Returns the winner both one-hot and as an index.
module rr_pick
   import counter_arbiter_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [IW-1:0] idx
);

   logic          found;
   logic [IW-1:0] j;

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!found && req[j]) begin
            found  = 1'b1;
            win[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting a shared down-counter to one requester.
// The grant holds until the count expires (done pulse) or is abandoned.
module counter_arbiter
   import counter_arbiter_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] val,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   done,
   output logic [W-1:0]   cnt,
   output logic           ready
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t        state, state_n;
   logic [N-1:0]  gnt_n, done_n;
   logic [W-1:0]  cnt_n;
   logic [IW-1:0] ptr, ptr_n;
   logic [IW-1:0] g, g_n;
   logic [IW-1:0] g_inc;
   logic [N-1:0]  win;
   logic [IW-1:0] win_idx;
   logic [W-1:0]  vals [N];

   for (genvar i = 0; i < N; i++) begin : g_val
      assign vals[i] = val[i*W +: W];
   end

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .win (win),
      .idx (win_idx)
   );

   assign ready = (state == IDLE);
   assign g_inc = (int'(g) == N - 1) ? '0 : g + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= '0;
         done  <= '0;
         cnt   <= '0;
         ptr   <= '0;
         g     <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         done  <= done_n;
         cnt   <= cnt_n;
         ptr   <= ptr_n;
         g     <= g_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      done_n  = '0;
      cnt_n   = cnt;
      ptr_n   = ptr;
      g_n     = g;
      unique case (state)
         IDLE: begin
            if (|req) begin
               gnt_n   = win;
               g_n     = win_idx;
               cnt_n   = vals[win_idx];
               state_n = COUNT;
            end
         end
         COUNT: begin
            // abandon wins over expiry on the same cycle
            if (!req[g]) begin
               gnt_n   = '0;
               ptr_n   = g_inc;
               state_n = IDLE;
            end else if (cnt == '0) begin
               done_n  = gnt;
               state_n = DONE;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         DONE: begin
            gnt_n   = '0;
            ptr_n   = g_inc;
            state_n = IDLE;
         end
         default: begin
            gnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Scenario bench for counter_arbiter; done pulses are matched against
// a queue of expected (requester, cycle) entries.
module tb_counter_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] val = '0;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [7:0]  cnt;
   logic        ready;

   typedef struct {
      logic [3:0] who;
      int         at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   counter_arbiter #(
      .N (4),
      .W (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .val   (val),
      .gnt   (gnt),
      .done  (done),
      .cnt   (cnt),
      .ready (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // every done pulse must match the oldest expected completion
   always @(negedge clk) begin
      if (done !== 4'b0000) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: done=%b at cycle %0d, required no pulse",
                     done, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (done !== mon_e.who || cyc != mon_e.at) begin
               errors++;
               $display("FAIL done_pulse: got %b at cycle %0d, required %b at cycle %0d",
                        done, cyc, mon_e.who, mon_e.at);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111;
      val = {4{8'd5}};
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
         errors++;
         $display("FAIL reset_gnt: got %b, required 0000", gnt);
      end
      checks++;
      if (cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d, required 0", cnt);
      end
      checks++;
      if (ready !== 1'b1 || done !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got ready=%b done=%b, required 1 0000",
                  ready, done);
      end
      rst = 1'b1;
      req = '0;
      tick();
      checks++;
      if (gnt !== 4'b0000 || ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_noreq: got gnt=%b ready=%b, required 0000 1",
                  gnt, ready);
      end
   endtask

   task automatic test_single();
      int k;
      do_reset();
      val[7:0] = 8'd3;
      req      = 4'b0001;
      k        = cyc + 1;
      sb.push_back('{4'b0001, k + 4});
      for (int t = 0; t < 4; t++) begin
         tick();
         checks++;
         if (gnt !== 4'b0001 || cnt !== 8'(3 - t) || ready !== 1'b0) begin
            errors++;
            $display("FAIL single_count t=%0d: got gnt=%b cnt=%0d ready=%b, required 0001 %0d 0",
                     t, gnt, cnt, ready, 3 - t);
         end
      end
      tick();
      checks++;
      if (gnt !== 4'b0001 || cnt !== 8'd0) begin
         errors++;
         $display("FAIL single_done_state: got gnt=%b cnt=%0d, required 0001 0",
                  gnt, cnt);
      end
      req = '0;
      tick();
      checks++;
      if (ready !== 1'b1 || gnt !== 4'b0000) begin
         errors++;
         $display("FAIL single_idle: got ready=%b gnt=%b, required 1 0000",
                  ready, gnt);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL single_pending: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_round_robin();
      int k;
      do_reset();
      val = {4{8'd1}};
      req = 4'b1111;
      k   = cyc + 1;
      for (int i = 0; i < 5; i++)
         sb.push_back('{4'(1 << (i % 4)), k + 2 + 4 * i});
      for (int t = 0; t <= 18; t++) begin
         tick();
         if (t % 4 == 0) begin
            checks++;
            if (gnt !== 4'(1 << ((t / 4) % 4))) begin
               errors++;
               $display("FAIL rr_grant t=%0d: got %b, required %b",
                        t, gnt, 4'(1 << ((t / 4) % 4)));
            end
         end
         if (t % 4 == 3) begin
            checks++;
            if (ready !== 1'b1 || gnt !== 4'b0000) begin
               errors++;
               $display("FAIL rr_gap t=%0d: got ready=%b gnt=%b, required 1 0000",
                        t, ready, gnt);
            end
         end
         if (t == 18) req = '0;
      end
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0000 || ready !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL rr_end: got gnt=%b ready=%b pending=%0d, required 0000 1 0",
                  gnt, ready, sb.size());
      end
   endtask

   task automatic test_zero_load();
      int k;
      do_reset();
      val[23:16] = 8'd0;
      req        = 4'b0100;
      k          = cyc + 1;
      sb.push_back('{4'b0100, k + 1});
      tick();
      checks++;
      if (gnt !== 4'b0100 || cnt !== 8'd0) begin
         errors++;
         $display("FAIL zero_grant: got gnt=%b cnt=%0d, required 0100 0", gnt, cnt);
      end
      tick();
      checks++;
      if (cnt !== 8'd0 || gnt !== 4'b0100) begin
         errors++;
         $display("FAIL zero_done: got gnt=%b cnt=%0d, required 0100 0", gnt, cnt);
      end
      req = '0;
      tick();
      checks++;
      if (ready !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL zero_idle: got ready=%b pending=%0d, required 1 0",
                  ready, sb.size());
      end
   endtask

   task automatic test_abandon();
      int k;
      do_reset();
      val[15:8] = 8'd10;
      req       = 4'b0010;
      k         = cyc + 1;
      for (int t = 0; t < 4; t++) begin
         tick();
         checks++;
         if (gnt !== 4'b0010 || cnt !== 8'(10 - t)) begin
            errors++;
            $display("FAIL abandon_count t=%0d: got gnt=%b cnt=%0d, required 0010 %0d",
                     t, gnt, cnt, 10 - t);
         end
      end
      req        = 4'b0101;
      val[23:16] = 8'd2;
      tick();
      checks++;
      if (gnt !== 4'b0000 || cnt !== 8'd7 || ready !== 1'b1) begin
         errors++;
         $display("FAIL abandon_drop: got gnt=%b cnt=%0d ready=%b, required 0000 7 1",
                  gnt, cnt, ready);
      end
      sb.push_back('{4'b0100, k + 8});
      tick();
      checks++;
      if (gnt !== 4'b0100 || cnt !== 8'd2) begin
         errors++;
         $display("FAIL abandon_next: got gnt=%b cnt=%0d, required 0100 2", gnt, cnt);
      end
      tick();
      tick();
      tick();
      req = '0;
      tick();
      checks++;
      if (ready !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL abandon_end: got ready=%b pending=%0d, required 1 0",
                  ready, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int k;
      do_reset();
      val[15:8] = 8'd0;
      req       = 4'b0010;
      k         = cyc + 1;
      sb.push_back('{4'b0010, k + 1});
      tick();
      tick();
      req = '0;
      tick();
      val[31:24] = 8'd8;
      val[7:0]   = 8'd1;
      req        = 4'b1001;
      k          = cyc + 1;
      tick();
      checks++;
      if (gnt !== 4'b1000 || cnt !== 8'd8) begin
         errors++;
         $display("FAIL mid_grant: got gnt=%b cnt=%0d, required 1000 8", gnt, cnt);
      end
      tick();
      tick();
      tick();
      checks++;
      if (cnt !== 8'd5) begin
         errors++;
         $display("FAIL mid_cnt: got %0d, required 5", cnt);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0000 || cnt !== 8'd0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got gnt=%b cnt=%0d ready=%b, required 0000 0 1",
                  gnt, cnt, ready);
      end
      tick();
      checks++;
      if (gnt !== 4'b0000) begin
         errors++;
         $display("FAIL mid_hold: got gnt=%b, required 0000", gnt);
      end
      rst = 1'b1;
      k   = cyc + 1;
      sb.push_back('{4'b0001, k + 2});
      tick();
      checks++;
      if (gnt !== 4'b0001 || cnt !== 8'd1) begin
         errors++;
         $display("FAIL mid_ptr: got gnt=%b cnt=%0d, required 0001 1", gnt, cnt);
      end
      tick();
      tick();
      req = '0;
      tick();
      checks++;
      if (ready !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL mid_end: got ready=%b pending=%0d, required 1 0",
                  ready, sb.size());
      end
   endtask

   task automatic test_val_change();
      int k;
      do_reset();
      val[7:0] = 8'd4;
      req      = 4'b0001;
      k        = cyc + 1;
      sb.push_back('{4'b0001, k + 5});
      for (int t = 0; t < 5; t++) begin
         tick();
         val = 32'($urandom());
         checks++;
         if (gnt !== 4'b0001 || cnt !== 8'(4 - t)) begin
            errors++;
            $display("FAIL valchg_count t=%0d: got gnt=%b cnt=%0d, required 0001 %0d",
                     t, gnt, cnt, 4 - t);
         end
      end
      tick();
      req = '0;
      tick();
      checks++;
      if (ready !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL valchg_end: got ready=%b pending=%0d, required 1 0",
                  ready, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_zero_load();
      test_abandon();
      test_reset_mid();
      test_val_change();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requesters.
REQ-002 The block SHALL have parameter W, default 8, down-counter width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-low reset: state is cleared on a clk rising edge while rst==0.
REQ-005 The block SHALL have port req, input, N, per-requester request level, held high until done or abandoned.
REQ-006 The block SHALL have port val, input, N*W, per-requester load value; slice i is val[i*W +: W].
REQ-007 The block SHALL have port gnt, output, N, one-hot grant: the requester currently owning the counter.
REQ-008 The block SHALL have port done, output, N, one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port cnt, output, W, current counter value.
REQ-010 The block SHALL have port ready, output, 1, high exactly when the state is IDLE.

Function
REQ-011 The block SHALL implement an FSM with three states: IDLE, COUNT, DONE.
REQ-012 IDLE, req==0: the FSM SHALL stay in IDLE with gnt==0 and done==0.
REQ-013 IDLE, req!=0: on the edge the FSM SHALL pick winner g by round-robin from pointer ptr, scanning ptr, ptr+1, ... mod N, first set bit wins.
REQ-014 On the same IDLE edge: gnt <= one-hot(g), cnt <= val slice g, state <= COUNT.
REQ-015 val SHALL be sampled only at the grant edge; later changes to val SHALL be ignored.
REQ-016 COUNT, req[g]==1, cnt!=0: cnt SHALL decrement by 1 per cycle.
REQ-017 COUNT, req[g]==1, cnt==0: the FSM SHALL go to DONE.
REQ-018 A load value of 0 SHALL follow the same path: COUNT with cnt==0, then DONE; it SHALL NOT be special-cased.
REQ-019 COUNT, req[g]==0 (abandon): the FSM SHALL go to IDLE with gnt cleared, no done pulse, cnt held, ptr <= (g+1) mod N.
REQ-020 Abandon SHALL take priority over the cnt==0 check on the same cycle.
REQ-021 DONE: done SHALL be one-hot(g) for exactly one cycle and gnt SHALL stay one-hot(g).
REQ-022 On the edge leaving DONE: gnt <= 0, ptr <= (g+1) mod N, state <= IDLE.
REQ-023 Latency: req sampled at edge k with value V SHALL give done high between edges k+V+1 and k+V+2.
REQ-024 The FSM SHALL spend at least one IDLE cycle between grants, so ready pulses high after every grant.
REQ-025 req bits of non-granted requesters SHALL NOT affect an ongoing grant.
REQ-026 ptr SHALL wrap from N-1 to 0.
REQ-027 cnt SHALL never underflow; the decrement happens only when cnt!=0.
REQ-028 gnt and done SHALL be register outputs and SHALL be glitch-free.

Reset
REQ-029 On an edge with rst==0 the block SHALL set: state=IDLE, gnt=0, done=0, cnt=0, ptr=0, ready=1 from the next cycle.
REQ-030 Reset SHALL override every state, including mid-COUNT and DONE; an interrupted grant SHALL produce no done pulse.
REQ-031 req and val SHALL be ignored while rst==0.

Structure
REQ-032 Package counter_arbiter_pkg SHALL hold the state encoding (IDLE=2'b00, COUNT=2'b01, DONE=2'b10) and the default N and W constants.
REQ-033 Sub-module rr_pick SHALL be the combinational round-robin picker: inputs req[N] and ptr; outputs one-hot winner and its index.
REQ-034 The counter, ptr and FSM registers SHALL live in counter_arbiter.

Verification
REQ-035 Scenario 1: reset, then req=4'b0001 with val0=3 sampled at edge k -> gnt=0001 from k, cnt shows 3,2,1,0, done=0001 only in the cycle after edge k+4, then ready=1.
REQ-036 Scenario 2: req=4'b1111 held, all val=1 -> grants in order 0001,0010,0100,1000,0001, each with exactly one done pulse.
REQ-037 Scenario 3: val2=0, req=4'b0100 -> done=0100 two cycles after the grant edge, cnt stays 0.
REQ-038 Scenario 4: requester 1 granted with val1=10, drops req after 4 cycles -> gnt returns to 0 with no done, next grant goes to requester 2 if it is requesting.
REQ-039 Scenario 5: rst=0 asserted mid-COUNT (cnt=5) -> next cycle gnt=0, cnt=0, done never pulses, ptr=0, so requester 0 wins the next arbitration.
REQ-040 Scenario 6: val changed during COUNT -> countdown is unaffected and done timing still matches REQ-023.
